// File: rtl/timer_slave.sv
// Memory-mapped machine timer: free-running 64-bit mtime with prescaler, 64-bit mtimecmp,
// byte-writable over a 32-bit word-addressed slave port, registered timer_irq level.
module timer_slave #(
   parameter int ClkDiv = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] address_in,
   input  logic        we_in,
   input  logic [31:0] wdata_in,
   input  logic [3:0]  wmask_in,
   output logic [31:0] rdata_out,
   output logic        timer_irq
);

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_timer_irq;

   logic        w_tick;
   logic        w_mtime_we;
   logic        w_cmp_we;
   logic [31:0] w_merged;
   logic [63:0] w_mtime_next;
   logic [63:0] w_cmp_next;
   logic        w_unused;

   // Only the low two word-address bits select a register; the rest belong to the decoder.
   assign w_unused   = &{1'b0, address_in[29:2]};
   assign w_mtime_we = we_in & ~address_in[1];
   assign w_cmp_we   = we_in &  address_in[1];

   always_comb begin
      w_merged = 32'h0;
      case (address_in[1:0])
         2'd0:    w_merged = r_mtime[31:0];
         2'd1:    w_merged = r_mtime[63:32];
         2'd2:    w_merged = r_mtimecmp[31:0];
         default: w_merged = r_mtimecmp[63:32];
      endcase
      for (int i = 0; i < 4; i++) begin
         if (wmask_in[i]) w_merged[8*i +: 8] = wdata_in[8*i +: 8];
      end
   end

   // A software write to mtime wins over the tick; the unwritten half is left untouched.
   always_comb begin
      w_mtime_next = r_mtime;
      if (w_mtime_we) begin
         if (address_in[0]) w_mtime_next[63:32] = w_merged;
         else               w_mtime_next[31:0]  = w_merged;
      end else if (w_tick) begin
         w_mtime_next = r_mtime + 64'd1;
      end
   end

   always_comb begin
      w_cmp_next = r_mtimecmp;
      if (w_cmp_we) begin
         if (address_in[0]) w_cmp_next[63:32] = w_merged;
         else               w_cmp_next[31:0]  = w_merged;
      end
   end

   generate
      if (ClkDiv == 1) begin : g_no_div
         assign w_tick = 1'b1;
      end else begin : g_div
         localparam int CW = $clog2(ClkDiv);
         logic [CW-1:0] r_div_cnt;

         assign w_tick = (r_div_cnt == CW'(ClkDiv - 1));

         // Restarting the period on an mtime write keeps software-set time aligned to a full period.
         always_ff @(posedge clk) begin
            if (rst || w_mtime_we) r_div_cnt <= '0;
            else if (w_tick)       r_div_cnt <= '0;
            else                   r_div_cnt <= r_div_cnt + CW'(1);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mtime     <= 64'h0;
         r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_timer_irq <= 1'b0;
      end else begin
         r_mtime     <= w_mtime_next;
         r_mtimecmp  <= w_cmp_next;
         r_timer_irq <= (r_mtime >= r_mtimecmp);
      end
   end

   always_comb begin
      rdata_out = 32'h0;
      case (address_in[1:0])
         2'd0:    rdata_out = r_mtime[31:0];
         2'd1:    rdata_out = r_mtime[63:32];
         2'd2:    rdata_out = r_mtimecmp[31:0];
         default: rdata_out = r_mtimecmp[63:32];
      endcase
   end

   assign timer_irq = r_timer_irq;

endmodule

// File: tb/tb_timer_slave.sv
// Bench for timer_slave: two instances (ClkDiv=1 and ClkDiv=4) share one bus and are
// compared against a model where mtime = value last set + edges since then / ClkDiv.
module tb_timer_slave;

   logic        clk;
   logic        rst;
   logic [29:0] address_in;
   logic        we_in;
   logic [31:0] wdata_in;
   logic [3:0]  wmask_in;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4;

   int n_checks = 0;
   int n_errors = 0;

   timer_slave #(.ClkDiv(1)) dut1 (
      .clk(clk), .rst(rst), .address_in(address_in), .we_in(we_in),
      .wdata_in(wdata_in), .wmask_in(wmask_in), .rdata_out(rdata1), .timer_irq(irq1)
   );

   timer_slave #(.ClkDiv(4)) dut4 (
      .clk(clk), .rst(rst), .address_in(address_in), .we_in(we_in),
      .wdata_in(wdata_in), .wmask_in(wmask_in), .rdata_out(rdata4), .timer_irq(irq4)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Reference model: index 0 is the ClkDiv=1 instance, index 1 the ClkDiv=4 instance.
   logic [63:0] m_base  [2];
   logic [63:0] m_since [2];
   logic [63:0] m_cmp   [2];
   logic        m_irq   [2];
   int          div_of  [2] = '{1, 4};

   function automatic logic [63:0] model_mtime(input int d);
      return m_base[d] + m_since[d] / 64'(div_of[d]);
   endfunction

   function automatic logic [31:0] apply_bytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] m);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) if (m[i]) res[8*i +: 8] = d[8*i +: 8];
      return res;
   endfunction

   function automatic logic [31:0] model_rd(input int d, input int a);
      logic [63:0] mt;
      mt = model_mtime(d);
      case (a)
         0:       return mt[31:0];
         1:       return mt[63:32];
         2:       return m_cmp[d][31:0];
         default: return m_cmp[d][63:32];
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic w, input logic [1:0] a,
                             input logic [31:0] d, input logic [3:0] m);
      logic [63:0] pre, nv;
      for (int k = 0; k < 2; k++) begin
         pre = model_mtime(k);
         if (r) begin
            m_base[k] = 64'h0; m_since[k] = 64'h0;
            m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF; m_irq[k] = 1'b0;
         end else begin
            m_irq[k] = (pre >= m_cmp[k]);
            if (w && !a[1]) begin
               nv = pre;
               if (a[0]) nv[63:32] = apply_bytes(pre[63:32], d, m);
               else      nv[31:0]  = apply_bytes(pre[31:0], d, m);
               m_base[k] = nv; m_since[k] = 64'h0;
            end else begin
               m_since[k] = m_since[k] + 64'd1;
            end
            if (w && a[1]) begin
               if (a[0]) m_cmp[k][63:32] = apply_bytes(m_cmp[k][63:32], d, m);
               else      m_cmp[k][31:0]  = apply_bytes(m_cmp[k][31:0], d, m);
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int a = 0; a < 4; a++) begin
         address_in[1:0] = 2'(a);
         #1;
         check($sformatf("div1_rd%0d", a), 64'(rdata1), 64'(model_rd(0, a)));
         check($sformatf("div4_rd%0d", a), 64'(rdata4), 64'(model_rd(1, a)));
      end
      check("div1_irq", 64'(irq1), 64'(m_irq[0]));
      check("div4_irq", 64'(irq4), 64'(m_irq[1]));
   endtask

   // Inputs change on the falling edge; outputs are checked shortly after the rising edge.
   task automatic step(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      logic [27:0] junk;
      junk = 28'($urandom());
      @(negedge clk);
      rst = r; we_in = w; address_in = {junk, a}; wdata_in = d; wmask_in = m;
      @(posedge clk);
      model_edge(r, w, a, d, m);
      #1;
      rst = 1'b0; we_in = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
   endtask

   task automatic peek(input string tag, input logic [1:0] a, input logic use4,
                       input logic [31:0] exp);
      address_in[1:0] = a;
      #1;
      check(tag, 64'(use4 ? rdata4 : rdata1), 64'(exp));
   endtask

   initial begin
      logic found;
      logic [1:0]  ra;
      logic [31:0] rd;
      rst = 1'b1; we_in = 1'b0; address_in = '0; wdata_in = '0; wmask_in = '0;
      for (int k = 0; k < 2; k++) begin
         m_base[k] = 0; m_since[k] = 0; m_cmp[k] = '1; m_irq[k] = 0;
      end

      // Reset values and plain counting.
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      peek("rst_lo", 2'd0, 1'b0, 32'h0);
      peek("rst_cmp_hi", 2'd3, 1'b0, 32'hFFFF_FFFF);
      check("rst_irq", 64'(irq1), 64'h0);
      idle(10);
      peek("count10", 2'd0, 1'b0, 32'd10);

      // Prescaler on the ClkDiv=4 instance.
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      idle(12);
      peek("div4_after12", 2'd0, 1'b1, 32'd3);
      idle(2);
      step(1'b0, 1'b1, 2'd0, 32'd100, 4'hF);
      idle(3);
      peek("div4_hold100", 2'd0, 1'b1, 32'd100);
      idle(1);
      peek("div4_step101", 2'd0, 1'b1, 32'd101);

      // Carry from low into high word, then full 64-bit wrap.
      step(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF);
      step(1'b0, 1'b1, 2'd1, 32'h0, 4'hF);
      idle(1);
      peek("carry_lo", 2'd0, 1'b0, 32'h0);
      peek("carry_hi", 2'd1, 1'b0, 32'h1);
      step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);
      step(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF);
      idle(1);
      peek("wrap_lo", 2'd0, 1'b0, 32'h0);
      peek("wrap_hi", 2'd1, 1'b0, 32'h0);
      idle(4);

      // Byte-masked write into mtimecmp low word.
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      step(1'b0, 1'b1, 2'd2, 32'h1234_5678, 4'b0101);
      peek("bytemask", 2'd2, 1'b0, 32'hFF34_FF78);

      // Interrupt rise one edge after mtime reaches mtimecmp, then clear on raise.
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
      idle(3);
      step(1'b0, 1'b1, 2'd3, 32'h0, 4'hF);
      step(1'b0, 1'b1, 2'd2, 32'd20, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         idle(1);
         address_in[1:0] = 2'd0;
         #1;
         if (rdata1 == 32'd20) begin
            found = 1'b1;
            check("irq_before", 64'(irq1), 64'h0);
            idle(1);
            check("irq_rise", 64'(irq1), 64'h1);
         end
      end
      check("irq_reach20", 64'(found), 64'h1);
      step(1'b0, 1'b1, 2'd2, 32'd1000, 4'hF);
      check("irq_still", 64'(irq1), 64'h1);
      idle(1);
      check("irq_clear", 64'(irq1), 64'h0);

      // Collisions: write beats tick; reset beats write.
      step(1'b0, 1'b1, 2'd0, 32'd7, 4'hF);
      peek("write_wins", 2'd0, 1'b0, 32'd7);
      step(1'b1, 1'b1, 2'd0, 32'd5, 4'hF);
      peek("rst_wins_lo", 2'd0, 1'b0, 32'h0);
      peek("rst_wins_cmp", 2'd2, 1'b0, 32'hFFFF_FFFF);

      // Random traffic; compare values kept small half the time so irq toggles.
      for (int i = 0; i < 400; i++) begin
         ra = 2'($urandom_range(0, 3));
         rd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom();
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) rd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            step(1'b0, 1'b1, ra, rd, 4'($urandom_range(0, 15)));
         end else if ($urandom_range(0, 99) == 0) begin
            step(1'b1, 1'($urandom_range(0, 1)), ra, rd, 4'hF);
         end else begin
            idle(1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
